// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/done handshake, operands and HI/LO results between
// ctrl_unit (master) and the multicycle MULT/DIV sequencer (slave).
interface muldiv_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hilo_write;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op, a, b,
        input  busy, done, hilo_write, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hilo_write, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multicycle sequencer for the MULT/DIV path feeding HI/LO.
// Runs a 32-step shift-add multiply or a 32-step restoring divide on operand
// magnitudes, then applies sign correction and pulses done/hilo_write once.
// Optional macro MULDIV_UNSIGNED_EN: when defined, op[1]=1 selects MULTU/DIVU;
// when undefined op[1] is ignored and every operation is signed.
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int               CNT_W     = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [63:0]      acc;      // {product hi / remainder, product lo / quotient}
    logic [31:0]      opnd;     // multiplicand or divisor magnitude
    logic             neg_q;    // negate product (mult) or quotient (div)
    logic             neg_r;    // negate remainder (follows dividend sign)
    logic             dz_pend;  // divisor was zero at accept

    logic is_unsigned;
`ifdef MULDIV_UNSIGNED_EN
    assign is_unsigned = bus.op[1];
`else
    logic unused_op_hi;
    assign unused_op_hi = bus.op[1];
    assign is_unsigned  = 1'b0;
`endif

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // Strip operand signs at accept time so the iterative core sees magnitudes only.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
        a_neg = ~is_unsigned & bus.a[31];
        b_neg = ~is_unsigned & bus.b[31];
        a_mag = a_neg ? (32'd0 - bus.a) : bus.a;
        b_mag = b_neg ? (32'd0 - bus.b) : bus.b;
    end

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // One multiply step, one restoring-divide step, and the sign-corrected results
    // of the step that is about to complete.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};

        // Shift the next dividend bit into the remainder and trial-subtract.
        div_diff = acc[63:31] - {1'b0, opnd};
        if (div_diff[32])
            div_next = {acc[62:0], 1'b0};
        else
            div_next = {div_diff[31:0], acc[30:0], 1'b1};

        prod_fix = neg_q ? (64'd0 - mul_next) : mul_next;
        quo_fix  = neg_q ? (32'd0 - div_next[31:0]) : div_next[31:0];
        rem_fix  = neg_r ? (32'd0 - div_next[63:32]) : div_next[63:32];
    end

    // Sequencer FSM, iteration datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state          <= S_IDLE;
            count          <= '0;
            acc            <= '0;
            opnd           <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            dz_pend        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.hilo_write <= 1'b0;
            bus.div_zero   <= 1'b0;
            bus.hi_out     <= '0;
            bus.lo_out     <= '0;
        end else begin
            bus.done       <= 1'b0;
            bus.hilo_write <= 1'b0;
            bus.div_zero   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        count    <= '0;
                        dz_pend  <= bus.op[0] && (bus.b == 32'd0);
                        if (!bus.op[0]) begin
                            state <= S_MULT;
                            acc   <= {32'd0, b_mag};
                            opnd  <= a_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= 1'b0;
                        end else begin
                            state <= S_DIV;
                            acc   <= {32'd0, a_mag};
                            opnd  <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                S_MULT: begin
                    acc   <= mul_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state          <= S_FIN;
                        bus.done       <= 1'b1;
                        bus.hilo_write <= 1'b1;
                        bus.hi_out     <= prod_fix[63:32];
                        bus.lo_out     <= prod_fix[31:0];
                    end
                end
                S_DIV: begin
                    if (dz_pend) begin
                        // Divide by zero: report it and leave HI/LO untouched.
                        state        <= S_FIN;
                        bus.done     <= 1'b1;
                        bus.div_zero <= 1'b1;
                    end else begin
                        acc   <= div_next;
                        count <= count + CNT_W'(1);
                        if (count == LAST_STEP) begin
                            state          <= S_FIN;
                            bus.done       <= 1'b1;
                            bus.hilo_write <= 1'b1;
                            bus.hi_out     <= rem_fix;
                            bus.lo_out     <= quo_fix;
                        end
                    end
                end
                S_FIN: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multicycle sequencer for the MULT/DIV path feeding the CPU's HI/LO registers and HI/LO muxes. It accepts operands from A/B under a start/done handshake from ctrl_unit. It runs a 32-iteration shift-add multiply or a 32-iteration restoring divide. On completion it presents HI/LO results with a one-cycle write strobe that drives WriteHILO. ctrl_unit stalls in a wait state while busy=1.

Parameters:
ITER, 32, number of iterations per operation; equals operand width; only 32 is supported.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  op[0]: 0=mult, 1=div; op[1]: 1=unsigned (only with the optional feature)
a  in  32  multiplicand / dividend (A register)
b  in  32  multiplier / divisor (B register)
busy  out  1  high from the accept edge until done drops
done  out  1  one-cycle completion pulse
hilo_write  out  1  one-cycle write strobe to HI/LO; coincides with done unless div by zero
div_zero  out  1  one-cycle pulse with done when the divisor is 0
hi_out  out  32  mult: product[63:32]; div: remainder
lo_out  out  32  mult: product[31:0]; div: quotient

Behaviour:
- All outputs and state are registered and update on the rising edge of clk.
- Reset: the FSM goes to IDLE. busy, done, hilo_write and div_zero are 0. hi_out, lo_out and the iteration counter are 0.
- Reset has priority over every other event. Reset mid-operation aborts the operation: no done pulse, no hilo_write, results cleared.
- FSM states: IDLE, MULT, DIV, FIN.
- IDLE:
  - If start=1 at edge E: latch |a| and |b| (or raw values when unsigned), record the result signs, and clear the counter.
  - Go to MULT (op[0]=0) or DIV (op[0]=1). busy=1 from E.
  - Div with b==0: go directly to FIN with div_zero pending. hi_out/lo_out are unchanged.
- MULT: one shift-add step per cycle on a 64-bit accumulator. The counter increments each cycle. After the 32nd step (edge E+32) go to FIN.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After the 32nd step (edge E+32) go to FIN.
- FIN (entered at edge E+32, or E+1 for div by zero):
  - Apply sign correction and load hi_out/lo_out.
  - done=1 for exactly one cycle. hilo_write=1 in the same cycle except on div by zero; then div_zero=1 and hilo_write=0.
  - Next edge: return to IDLE with busy=0 and done=0.
- Latency: done is high in cycle E+32..E+33 for normal operations, and E+1..E+2 for div by zero. start may be re-accepted on the edge FIN exits to IDLE +1, i.e. in the first IDLE cycle.
- start while busy is ignored. The operands and the in-flight operation are unaffected.
- Signed mult: 64-bit two's-complement product. The product is negated when the operand signs differ.
- Signed div:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000, hi_out=0. This is the natural wrap; no exception is raised.
- hi_out/lo_out hold their last values between operations. They are valid whenever done=1.
- a, b and op may change after the accept edge without effect.

Optional Feature:
MULDIV_UNSIGNED_EN
- Defined: op[1]=1 selects MULTU/DIVU. Operands are used as raw unsigned values with no sign correction.
- Undefined: op[1] is ignored and all operations are signed. The unsigned datapath logic is not synthesized.

Test Plan:
- Signed mult: start, op=00, a=7, b=0xFFFFFFFD -> busy during 33 cycles. done and hilo_write pulse once at E+32: hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
- Signed div, positive dividend: op=01, a=100, b=0xFFFFFFF9 (-7) -> lo_out=0xFFFFFFF2 (-14), hi_out=0x00000002, hilo_write=1.
- Signed div, negative dividend: a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- Divide by zero: after the previous test, div with b=0 -> done and div_zero at E+1, hilo_write=0, hi_out/lo_out unchanged (0xFFFFFFFF/0xFFFFFFFD).
- Robustness: start re-asserted with new operands at E+5 is ignored and the first result is unaffected. reset asserted at E+10 gives IDLE next edge, busy=0, outputs 0, and no done pulse.
- With MULDIV_UNSIGNED_EN, a=0xFFFFFFFF, b=2:
  - op=10 -> hi_out=0x00000001, lo_out=0xFFFFFFFE.
  - op=00 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFE.
  - Without the macro, op=10 gives the signed result.
